// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   Raster timing source for the starfield/pixel pipeline. Free-running
//   horizontal/vertical counters produce sync pulses, an active-video flag,
//   a field window with an end-of-field strobe, and a frame-start strobe.
//   Every output is registered, and all outputs describe the same pixel
//   (hpos, vpos) in the same cycle.
//
//   Optional feature: define VGA_TIMING_FRAME_CNT_EN to build the
//   completed-frame counter. Without it, frame_cnt is tied to 0 and no
//   counter flops are built. The port list is the same in both builds.
//
// Ports
//   clk          in   pixel clock
//   reset        in   synchronous, active-high; takes priority over ce
//   ce           in   pixel-advance enable; 0 freezes all state and outputs
//   hpos         out  current column, 0..H_TOTAL-1
//   vpos         out  current line, 0..V_TOTAL-1
//   hsync        out  horizontal sync, level SYNC_POL while active
//   vsync        out  vertical sync, level SYNC_POL while active
//   display_on   out  hpos < H_VIS && vpos < V_VIS
//   field_en     out  hpos < FIELD_W && vpos < FIELD_H
//   field_last   out  high only at pixel (FIELD_W-1, FIELD_H-1)
//   frame_start  out  high only at pixel (0,0)
//   frame_cnt    out  completed-frame count (0 unless VGA_TIMING_FRAME_CNT_EN)
module vga_timing_gen #(
  parameter int H_VIS       = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_VIS       = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int SYNC_POL    = 0,
  parameter int FIELD_W     = 640,
  parameter int FIELD_H     = 480,
  parameter int FRAME_CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ce,
  output logic [9:0]             hpos,
  output logic [9:0]             vpos,
  output logic                   hsync,
  output logic                   vsync,
  output logic                   display_on,
  output logic                   field_en,
  output logic                   field_last,
  output logic                   frame_start,
  output logic [FRAME_CNT_W-1:0] frame_cnt
);

  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS_L  = 10'(H_VIS);
  localparam logic [9:0] V_VIS_L  = 10'(V_VIS);
  localparam logic [9:0] HS_BEG   = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG   = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_VIS + V_FP + V_SYNC);
  localparam logic [9:0] FLD_W_L  = 10'(FIELD_W);
  localparam logic [9:0] FLD_H_L  = 10'(FIELD_H);
  localparam logic [9:0] FLD_LX   = 10'(FIELD_W - 1);
  localparam logic [9:0] FLD_LY   = 10'(FIELD_H - 1);
  localparam logic       SYNC_ACT = (SYNC_POL != 0) ? 1'b1 : 1'b0;

  if (FIELD_W > H_VIS || FIELD_H > V_VIS || FIELD_W < 1 || FIELD_H < 1) begin : g_param_err
    $error("vga_timing_gen: field window %0dx%0d does not fit the visible area %0dx%0d",
           FIELD_W, FIELD_H, H_VIS, V_VIS);
  end

  // Next-pixel counters: hold the pixel that the output stage presents on the
  // following ce edge, so every flag can be decoded and registered in step.
  logic [9:0] hcnt_q, hcnt_d;
  logic [9:0] vcnt_q, vcnt_d;

  logic [9:0] hpos_q, vpos_q;
  logic       hsync_q, vsync_q, display_on_q, field_en_q, field_last_q, frame_start_q;

  logic       hsync_d, vsync_d, display_on_d, field_en_d, field_last_d, frame_start_d;

  always_comb begin
    hcnt_d = hcnt_q + 10'd1;
    vcnt_d = vcnt_q;
    if (hcnt_q == H_LAST) begin
      hcnt_d = 10'd0;
      vcnt_d = (vcnt_q == V_LAST) ? 10'd0 : vcnt_q + 10'd1;
    end
  end

  always_comb begin
    hsync_d       = (hcnt_q >= HS_BEG && hcnt_q < HS_END) ? SYNC_ACT : ~SYNC_ACT;
    vsync_d       = (vcnt_q >= VS_BEG && vcnt_q < VS_END) ? SYNC_ACT : ~SYNC_ACT;
    display_on_d  = (hcnt_q < H_VIS_L) && (vcnt_q < V_VIS_L);
    field_en_d    = (hcnt_q < FLD_W_L) && (vcnt_q < FLD_H_L);
    field_last_d  = (hcnt_q == FLD_LX) && (vcnt_q == FLD_LY);
    frame_start_d = (hcnt_q == 10'd0) && (vcnt_q == 10'd0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hcnt_q        <= 10'd0;
      vcnt_q        <= 10'd0;
      hpos_q        <= 10'd0;
      vpos_q        <= 10'd0;
      hsync_q       <= ~SYNC_ACT;
      vsync_q       <= ~SYNC_ACT;
      display_on_q  <= 1'b0;
      field_en_q    <= 1'b0;
      field_last_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else if (ce) begin
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      hpos_q        <= hcnt_q;
      vpos_q        <= vcnt_q;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      display_on_q  <= display_on_d;
      field_en_q    <= field_en_d;
      field_last_q  <= field_last_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign hpos        = hpos_q;
  assign vpos        = vpos_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign display_on  = display_on_q;
  assign field_en    = field_en_q;
  assign field_last  = field_last_q;
  assign frame_start = frame_start_q;

`ifdef VGA_TIMING_FRAME_CNT_EN
  // first_q suppresses the count on the frame_start that follows reset, so
  // the first frame reads 0 and the second frame_start brings it to 1.
  logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic                   first_q;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (frame_start_d && !first_q) frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt_q <= '0;
      first_q     <= 1'b1;
    end else if (ce) begin
      frame_cnt_q <= frame_cnt_d;
      first_q     <= 1'b0;
    end
  end

  assign frame_cnt = frame_cnt_q;
`else
  assign frame_cnt = '0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic reset;
  logic ce;

  always #5 clk = ~clk;

  // Full-size 640x480 timing for line-level behaviour.
  logic [9:0] b_hpos, b_vpos;
  logic       b_hsync, b_vsync, b_disp, b_fen, b_flast, b_fstart;
  logic [7:0] b_fcnt;

  vga_timing_gen u_big (
    .clk(clk), .reset(reset), .ce(ce),
    .hpos(b_hpos), .vpos(b_vpos), .hsync(b_hsync), .vsync(b_vsync),
    .display_on(b_disp), .field_en(b_fen), .field_last(b_flast),
    .frame_start(b_fstart), .frame_cnt(b_fcnt)
  );

  // Miniature raster (25 x 13 = 325 pixels/frame) for frame-level behaviour.
  // hsync active hpos 18..20, vsync active vpos 9..10, field 5x3, last (4,2).
  localparam int SH = 25;
  localparam int SV = 13;
  localparam int SF = SH * SV;

  logic [9:0] s_hpos, s_vpos;
  logic       s_hsync, s_vsync, s_disp, s_fen, s_flast, s_fstart;
  logic [1:0] s_fcnt;

  vga_timing_gen #(
    .H_VIS(16), .H_FP(2), .H_SYNC(3), .H_BP(4),
    .V_VIS(8), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .SYNC_POL(0), .FIELD_W(5), .FIELD_H(3), .FRAME_CNT_W(2)
  ) u_small (
    .clk(clk), .reset(reset), .ce(ce),
    .hpos(s_hpos), .vpos(s_vpos), .hsync(s_hsync), .vsync(s_vsync),
    .display_on(s_disp), .field_en(s_fen), .field_last(s_flast),
    .frame_start(s_fstart), .frame_cnt(s_fcnt)
  );

  int checks = 0;
  int passed = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int disp_cnt, hs_cnt, hs_first, hs_last, seq_err;
    int fs_cnt, fs_err, vs_cnt, vs_err, hs_small, fe_cnt, fl_cnt, fl_err, wraps, fc_err;
    int prev_v, exp_fc;

    reset = 1'b1;
    ce    = 1'b1;
    tick(3);

    // Reset state
    chk("rst_hpos", b_hpos, 0);
    chk("rst_vpos", b_vpos, 0);
    chk("rst_hsync", b_hsync, 1);
    chk("rst_vsync", b_vsync, 1);
    chk("rst_flags", {b_disp, b_fen, b_flast, b_fstart}, 0);
    chk("rst_fcnt", b_fcnt, 0);
    chk("rst_small_flags", {s_disp, s_fen, s_flast, s_fstart, s_hsync, s_vsync}, 2'b11);

    // First edge after release presents pixel (0,0)
    reset = 1'b0;
    tick(1);
    chk("first_hpos", b_hpos, 0);
    chk("first_vpos", b_vpos, 0);
    chk("first_disp", b_disp, 1);
    chk("first_fen", b_fen, 1);
    chk("first_fstart", b_fstart, 1);
    chk("first_sync", {b_hsync, b_vsync}, 2'b11);

    // One full line on the full-size raster
    disp_cnt = 0; hs_cnt = 0; hs_first = -1; hs_last = -1; seq_err = 0;
    for (int i = 0; i < 800; i++) begin
      if (b_hpos !== 10'(i) || b_vpos !== 10'd0) seq_err++;
      if (b_disp === 1'b1) disp_cnt++;
      if (b_hsync === 1'b0) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = i;
        hs_last = i;
      end
      if (b_fstart !== (i == 0)) seq_err++;
      tick(1);
    end
    chk("line_seq", seq_err, 0);
    chk("line_disp_cnt", disp_cnt, 640);
    chk("line_hs_cnt", hs_cnt, 96);
    chk("line_hs_first", hs_first, 656);
    chk("line_hs_last", hs_last, 751);
    chk("line_wrap_hpos", b_hpos, 0);
    chk("line_wrap_vpos", b_vpos, 1);

    // ce freeze at hpos=100
    tick(100);
    chk("pre_freeze_hpos", b_hpos, 100);
    ce = 1'b0;
    tick(5);
    chk("freeze_hpos", b_hpos, 100);
    chk("freeze_vpos", b_vpos, 1);
    chk("freeze_flags", {b_disp, b_fen, b_hsync, b_vsync, b_fstart}, 5'b11110);
    ce = 1'b1;
    tick(1);
    chk("resume_hpos", b_hpos, 101);

    // Reset mid-frame at (400,1)
    tick(299);
    chk("pre_rst_hpos", b_hpos, 400);
    reset = 1'b1;
    tick(1);
    chk("midrst_pos", {b_hpos, b_vpos}, 0);
    chk("midrst_flags", {b_disp, b_fen, b_flast, b_fstart, b_hsync, b_vsync}, 2'b11);
    reset = 1'b0;
    tick(1);
    chk("recover_fstart", b_fstart, 1);
    chk("recover_pos", {b_hpos, b_vpos}, 0);

    // Five frames on the miniature raster, starting at its (0,0)
    fs_cnt = 0; fs_err = 0; vs_cnt = 0; vs_err = 0; hs_small = 0; fe_cnt = 0;
    fl_cnt = 0; fl_err = 0; wraps = 0; fc_err = 0; prev_v = -1;
    for (int i = 0; i < 5 * SF; i++) begin
      if (s_hpos !== 10'(i % SH) || s_vpos !== 10'((i % SF) / SH)) fs_err++;
      if (s_fstart === 1'b1) fs_cnt++;
      if (s_fstart !== ((i % SF) == 0)) fs_err++;
      if (s_vsync !== !((i % SF) / SH == 9 || (i % SF) / SH == 10)) vs_err++;
      if (i < SF && s_vsync === 1'b0) vs_cnt++;
      if (i < SF && s_hsync === 1'b0) hs_small++;
      if (i < SF && s_fen === 1'b1) fe_cnt++;
      if (s_flast === 1'b1) fl_cnt++;
      if (s_flast !== ((i % SH) == 4 && (i % SF) / SH == 2)) fl_err++;
      if (prev_v == 12 && s_vpos === 10'd0) wraps++;
      prev_v = int'(s_vpos);
`ifdef VGA_TIMING_FRAME_CNT_EN
      exp_fc = (i / SF) % 4;
`else
      exp_fc = 0;
`endif
      if (s_fcnt !== 2'(exp_fc)) fc_err++;
      tick(1);
    end
    chk("frm_seq", fs_err, 0);
    chk("frm_fstart_cnt", fs_cnt, 5);
    chk("frm_vs_lines", vs_err, 0);
    chk("frm_vs_cnt", vs_cnt, 2 * SH);
    chk("frm_hs_cnt", hs_small, 3 * SV);
    chk("frm_fen_cnt", fe_cnt, 15);
    chk("frm_flast_cnt", fl_cnt, 5);
    chk("frm_flast_pos", fl_err, 0);
    chk("frm_vwrap", wraps, 4);
    chk("frm_fcnt", fc_err, 0);

    // Strobe stays high while frozen
    chk("strobe_pre", s_fstart, 1);
    ce = 1'b0;
    tick(3);
    chk("strobe_frozen", {s_fstart, s_hpos, s_vpos}, {1'b1, 20'd0});
    ce = 1'b1;
    tick(1);
    chk("strobe_release", {s_fstart, s_hpos}, {1'b0, 10'd1});
`ifdef VGA_TIMING_FRAME_CNT_EN
    chk("fcnt_after", s_fcnt, 1);
`else
    chk("fcnt_after", s_fcnt, 0);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
